// File: rtl/smg_loader_pkg.sv
// rtl/smg_loader_pkg.sv - shared types and defaults for the smg program loader
// Purpose: loader FSM state encoding plus default frame marker and memory widths.
// Ports: none (package).
package smg_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         ADDR_W_DEFAULT    = 16;
   localparam int         DATA_W_DEFAULT    = 8;

endpackage

// File: rtl/smg_program_loader.sv
// rtl/smg_program_loader.sv - framed byte-stream writer that preloads smg memory
// Purpose: parses SYNC, addr(16b BE), len(16b BE), payload and issues one memory
//   write per payload byte; holds the smg core in reset until the image is written.
// Optional feature: LOADER_CHECKSUM_EN adds a trailing checksum byte (CHECK state).
// Ports:
//   clk, reset (sync, active-low)
//   inValid/inByte/inReady          byte stream in, transfer = inValid & inReady
//   memReady/memWriteEnable/memAddress/memWriteData   memory write port
//   cpuReset (active-high to smg), loadDone, loadError (sticky status)
module smg_program_loader
   import smg_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int         ADDR_W    = ADDR_W_DEFAULT,
   parameter int         DATA_W    = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inValid,
   input  logic [DATA_W-1:0] inByte,
   output logic              inReady,
   input  logic              memReady,
   output logic              memWriteEnable,
   output logic [ADDR_W-1:0] memAddress,
   output logic [DATA_W-1:0] memWriteData,
   output logic              cpuReset,
   output logic              loadDone,
   output logic              loadError
);

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t AFTER_DATA = ST_CHECK;
   logic [7:0] sum;
`else
   localparam loader_state_t AFTER_DATA = ST_DONE;
   assign loadError = 1'b0;
`endif

   loader_state_t state;
   logic [15:0]   curAddr;
   logic [15:0]   remaining;
   logic          stateReady;
   logic          xfer;

   always_comb begin
      stateReady = 1'b0;
      case (state)
         ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_LEN_HI, ST_LEN_LO, ST_CHECK: stateReady = 1'b1;
         ST_DATA: stateReady = memReady;
         default: stateReady = 1'b0;
      endcase
   end

   // Gated by reset so the loader never advertises readiness while held in reset.
   assign inReady = reset & stateReady;
   assign xfer    = inValid & inReady;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ST_IDLE;
         curAddr        <= '0;
         remaining      <= '0;
         memWriteEnable <= 1'b0;
         memAddress     <= '0;
         memWriteData   <= '0;
         cpuReset       <= 1'b1;
         loadDone       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         loadError      <= 1'b0;
         sum            <= '0;
`endif
      end else begin
         memWriteEnable <= 1'b0;
         case (state)
            ST_IDLE:    if (xfer && inByte[7:0] == SYNC_BYTE) state <= ST_ADDR_HI;
            ST_ADDR_HI: if (xfer) begin
               curAddr[15:8] <= inByte[7:0];
               state         <= ST_ADDR_LO;
            end
            ST_ADDR_LO: if (xfer) begin
               curAddr[7:0] <= inByte[7:0];
               state        <= ST_LEN_HI;
            end
            ST_LEN_HI:  if (xfer) begin
               remaining[15:8] <= inByte[7:0];
               state           <= ST_LEN_LO;
            end
            ST_LEN_LO:  if (xfer) begin
               remaining[7:0] <= inByte[7:0];
`ifdef LOADER_CHECKSUM_EN
               sum            <= '0;
`endif
               // An empty image skips DATA entirely.
               state <= ({remaining[15:8], inByte[7:0]} == 16'd0) ? AFTER_DATA : ST_DATA;
            end
            ST_DATA:    if (xfer) begin
               memWriteEnable <= 1'b1;
               memAddress     <= ADDR_W'(curAddr);
               memWriteData   <= inByte;
               curAddr        <= curAddr + 16'd1;
               remaining      <= remaining - 16'd1;
`ifdef LOADER_CHECKSUM_EN
               sum            <= sum + inByte[7:0];
`endif
               if (remaining == 16'd1) state <= AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:   if (xfer) begin
               state <= (8'(sum + inByte[7:0]) == 8'h00) ? ST_DONE : ST_ERROR;
            end
            ST_ERROR: begin
               loadError <= 1'b1;
            end
`endif
            // Status lands one cycle after the final strobe; sticky until reset.
            ST_DONE: begin
               loadDone <= 1'b1;
               cpuReset <= 1'b0;
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_smg_program_loader.sv
// tb/tb_smg_program_loader.sv - directed vector bench for smg_program_loader
module tb_smg_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        inValid = 1'b0;
   logic [7:0]  inByte = 8'h00;
   logic        inReady;
   logic        memReady = 1'b1;
   logic        memWriteEnable;
   logic [15:0] memAddress;
   logic [7:0]  memWriteData;
   logic        cpuReset;
   logic        loadDone;
   logic        loadError;

   int checks = 0;
   int errors = 0;

   smg_program_loader dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inByte(inByte), .inReady(inReady),
      .memReady(memReady), .memWriteEnable(memWriteEnable), .memAddress(memAddress),
      .memWriteData(memWriteData), .cpuReset(cpuReset), .loadDone(loadDone),
      .loadError(loadError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        v;
      logic [7:0]  b;
      logic        mr;
      logic        rdy;
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      logic        cpu;
      logic        done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic v, input logic [7:0] b, input logic mr,
                      input logic rdy, input logic we, input logic [15:0] a,
                      input logic [7:0] d, input logic cpu, input logic done);
      vec_t t;
      t.rst = rst; t.v = v; t.b = b; t.mr = mr; t.rdy = rdy; t.we = we;
      t.a = a; t.d = d; t.cpu = cpu; t.done = done;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Bytes with identical expected outputs and no DATA activity.
   task automatic addIdle(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
      add(1, 1, b, 1, 1, 0, a, d, 1, 0);
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic sendByte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      inValid = 1'b1; inByte = b; #1;
      while (!inReady && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!inReady) begin
         errors++;
         $display("FAIL sendByte timeout: inReady=%b expected 1", inReady);
      end
      @(posedge clk); #1;
      inValid = 1'b0;
   endtask

   task automatic runFrame(input logic [7:0] ck, input logic expDone);
      logic [7:0] f [9];
      f = '{8'hA5, 8'h00, 8'h13, 8'h00, 8'h03, 8'h08, 8'h11, 8'h02, ck};
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      foreach (f[i]) sendByte(f[i]);
      repeat (3) @(negedge clk);
      #1;
      chk("ck_loadDone", 0, 16'(loadDone), 16'(expDone));
      chk("ck_loadError", 0, 16'(loadError), 16'(!expDone));
      chk("ck_cpuReset", 0, 16'(cpuReset), 16'(!expDone));
   endtask
`endif

   initial begin
      // Test 1: three-byte image at 0x0013
      add(0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 1, 0);
      addIdle(8'hA5, 0, 0); addIdle(8'h00, 0, 0); addIdle(8'h13, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h03, 0, 0); addIdle(8'h08, 0, 0);
      add(1, 1, 8'h11, 1, 1, 1, 16'h0013, 8'h08, 1, 0);
      add(1, 1, 8'h02, 1, 1, 1, 16'h0014, 8'h11, 1, 0);
      add(1, 0, 8'h00, 1, 0, 1, 16'h0015, 8'h02, 1, 0);
      add(1, 1, 8'h55, 1, 0, 0, 16'h0015, 8'h02, 0, 1);
      // Test 2: junk in IDLE, zero-length frame
      add(0, 0, 8'h00, 1, 0, 0, 16'h0015, 8'h02, 0, 1);
      addIdle(8'h3C, 0, 0); addIdle(8'h7E, 0, 0); addIdle(8'hA5, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h20, 0, 0); addIdle(8'h00, 0, 0); addIdle(8'h00, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 0, 1);
      // Test 3: address wrap 0xFFFF -> 0x0000
      add(0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 0, 1);
      addIdle(8'hA5, 0, 0); addIdle(8'hFF, 0, 0); addIdle(8'hFF, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h02, 0, 0); addIdle(8'hAA, 0, 0);
      add(1, 1, 8'hBB, 1, 1, 1, 16'hFFFF, 8'hAA, 1, 0);
      add(1, 0, 8'h00, 1, 0, 1, 16'h0000, 8'hBB, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 16'h0000, 8'hBB, 0, 1);
      // Test 4: memory backpressure mid-DATA
      add(0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'hBB, 0, 1);
      addIdle(8'hA5, 0, 0); addIdle(8'h00, 0, 0); addIdle(8'h40, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h02, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 1, 8'h11, 0, 0, 0, 16'h0000, 8'h00, 1, 0);
      add(1, 1, 8'h11, 1, 1, 0, 16'h0000, 8'h00, 1, 0);
      add(1, 1, 8'h22, 0, 0, 1, 16'h0040, 8'h11, 1, 0);
      add(1, 1, 8'h22, 1, 1, 0, 16'h0040, 8'h11, 1, 0);
      add(1, 0, 8'h00, 1, 0, 1, 16'h0041, 8'h22, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 16'h0041, 8'h22, 0, 1);
      // Test 6: reset after the second payload byte, then a fresh frame
      add(0, 0, 8'h00, 1, 0, 0, 16'h0041, 8'h22, 0, 1);
      addIdle(8'hA5, 0, 0); addIdle(8'h00, 0, 0); addIdle(8'h50, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h04, 0, 0); addIdle(8'h01, 0, 0);
      add(1, 1, 8'h02, 1, 1, 1, 16'h0050, 8'h01, 1, 0);
      add(0, 1, 8'h03, 1, 0, 1, 16'h0051, 8'h02, 1, 0);
      add(0, 0, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 1, 0);
      addIdle(8'hA5, 0, 0); addIdle(8'h00, 0, 0); addIdle(8'h60, 0, 0);
      addIdle(8'h00, 0, 0); addIdle(8'h01, 0, 0); addIdle(8'h77, 0, 0);
      add(1, 0, 8'h00, 1, 0, 1, 16'h0060, 8'h77, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 16'h0060, 8'h77, 0, 1);

      reset = 1'b0;
      repeat (2) @(posedge clk);

`ifdef LOADER_CHECKSUM_EN
      runFrame(8'hE5, 1'b1);
      runFrame(8'hE4, 1'b0);
`else
      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst; inValid = vecs[i].v; inByte = vecs[i].b; memReady = vecs[i].mr;
         #1;
         chk("inReady", i, 16'(inReady), 16'(vecs[i].rdy));
         chk("memWriteEnable", i, 16'(memWriteEnable), 16'(vecs[i].we));
         chk("memAddress", i, memAddress, vecs[i].a);
         chk("memWriteData", i, 16'(memWriteData), 16'(vecs[i].d));
         chk("cpuReset", i, 16'(cpuReset), 16'(vecs[i].cpu));
         chk("loadDone", i, 16'(loadDone), 16'(vecs[i].done));
         chk("loadError", i, 16'(loadError), 16'h0000);
      end

      // DONE is sticky: a new sync byte is neither accepted nor written.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         inValid = 1'b1; inByte = 8'hA5; memReady = 1'b1;
         #1;
         chk("sticky_inReady", i, 16'(inReady), 16'h0000);
         chk("sticky_we", i, 16'(memWriteEnable), 16'h0000);
         chk("sticky_loadDone", i, 16'(loadDone), 16'h0001);
         chk("sticky_cpuReset", i, 16'(cpuReset), 16'h0000);
      end
      inValid = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
